amiga_pll_sequencer: RTL and testbench
======================================

AMIGA_PLL_SEQUENCER -- requirements
Module: amiga_pll_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles that pll_rst is held high per reset attempt (minimum 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 74250: cycles allowed in WAIT_LOCK before a retry (1 ms at 74.25 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRY, default 4: number of failed attempts before FAULT.
REQ-005 SHALL have port clk_74a, input, 1 bit: the single clock, which is the PLL reference clock.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port pll_locked, input, 1 bit: raw PLL locked flag, asynchronous to clk_74a.
REQ-008 SHALL have port reconfig_req, input, 1 bit: single-cycle request to restart the PLL (e.g. PAL/NTSC change).
REQ-009 SHALL have port pll_rst, output, 1 bit: PLL reset, active-high.
REQ-010 SHALL have port core_reset_n, output, 1 bit: core reset for the generated clock domains, active-low.
REQ-011 SHALL have port ready, output, 1 bit: high while the state is RUN.
REQ-012 SHALL have port fault, output, 1 bit: high while the state is FAULT.
REQ-013 SHALL have port loss_cnt, output, 8 bits: count of lock losses seen in RUN.
REQ-014 SHALL have port state_o, output, 3 bits: state encoding RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer, giving lock_s; all decisions use lock_s, which adds 2 cycles of latency.
REQ-016 SHALL, in RESET, drive pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with pll_rst=0.
REQ-017 SHALL, in WAIT_LOCK, go to STABLE when lock_s=1.
REQ-018 SHALL, in WAIT_LOCK, on the cycle the LOCK_TIMEOUT count expires, increment retry_cnt and go to RESET.
REQ-019 SHALL make that timeout transition go to FAULT instead when retry_cnt+1 equals MAX_RETRY.
REQ-020 SHALL, in STABLE, go to RUN after STABLE_CYCLES consecutive cycles with lock_s=1.
REQ-021 SHALL, in STABLE, return to WAIT_LOCK with a fresh timeout on any cycle with lock_s=0; retry_cnt is unchanged.
REQ-022 SHALL register core_reset_n and ready so both rise on the first RUN cycle, and clear retry_cnt on entry to RUN.
REQ-023 SHALL, in RUN, on lock_s=0, drop core_reset_n and ready in that same cycle's registered update.
REQ-024 SHALL, on that RUN lock loss, increment loss_cnt (saturating at 255) and go to RESET.
REQ-025 SHALL hold FAULT with pll_rst=0 and core_reset_n=0; FAULT is left only via reconfig_req or reset_n.
REQ-026 SHALL treat reconfig_req=1 in any state as highest priority: go to RESET, clear retry_cnt, reset all timers, and drive core_reset_n=0.
REQ-027 SHALL NOT increment loss_cnt when reconfig_req and a RUN lock loss occur in the same cycle.
REQ-028 SHALL restart the RST_CYCLES count when reconfig_req arrives during RESET.
REQ-029 SHALL keep core_reset_n=0 in every state except RUN.
REQ-030 SHALL size counters to clog2(max(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES)+1) bits, with no wrap before expiry.

Reset
REQ-031 SHALL, while reset_n=0, asynchronously force state=RESET, pll_rst=1, core_reset_n=0, ready=0, fault=0, loss_cnt=0, retry_cnt=0, synchronizer flops=0, and all counters=0.
REQ-032 SHALL begin the RESET count on the first clk_74a edge after reset_n rises.
REQ-033 SHALL, when reset_n is asserted mid-operation (including in RUN), drop core_reset_n immediately without waiting for a clock edge.

Verification (bench parameters RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-034 SHALL verify normal bring-up.
- Stimulus: release reset_n; pll_locked rises 20 cycles after pll_rst falls.
- Response: pll_rst high exactly 4 cycles; ready and core_reset_n rise 2+8 cycles after pll_locked rises; state_o=3.
REQ-035 SHALL verify retry then fault.
- Stimulus: pll_locked held at 0.
- Response: WAIT_LOCK expires after 100 cycles, then a second RESET pulse of 4 cycles; the second timeout gives state_o=4, fault=1, pll_rst=0.
REQ-036 SHALL verify a glitch during STABLE.
- Stimulus: pll_locked drops for 3 cycles at STABLE cycle 5.
- Response: return to WAIT_LOCK; after re-lock, a full 8 consecutive cycles are needed before RUN; loss_cnt=0.
REQ-037 SHALL verify lock loss in RUN.
- Stimulus: in RUN, pll_locked falls.
- Response: core_reset_n=0 and ready=0 within 3 cycles; loss_cnt=1; pll_rst pulses 4 cycles; re-lock returns to RUN.
REQ-038 SHALL verify reconfig priority.
- Stimulus: reconfig_req in the same cycle as lock_s falls in RUN.
- Response: state RESET; loss_cnt unchanged.
- Stimulus: reconfig_req while in FAULT.
- Response: fault=0; a new 4-cycle pll_rst pulse.
REQ-039 SHALL verify asynchronous reset in RUN.
- Stimulus: assert reset_n low between clock edges while in RUN.
- Response: core_reset_n=0 and pll_rst=1 before the next edge; loss_cnt=0.

Source files
------------

// File: rtl/amiga_pll_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a stable lock, releases the
// core reset, and retries or faults when lock never arrives.
module amiga_pll_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 74250,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       reconfig_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_o
);

  localparam int MAXA = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int MAXV = (MAXA > RST_CYCLES) ? MAXA : RST_CYCLES;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int RW   = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry_cnt;
  logic          lock_m, lock_s;

  assign state_o = state;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_RESET;
      cnt          <= '0;
      retry_cnt    <= '0;
      lock_m       <= 1'b0;
      lock_s       <= 1'b0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      fault        <= 1'b0;
      loss_cnt     <= '0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
      if (reconfig_req) begin
        // Restart wins over everything, including a same-cycle lock loss.
        state        <= S_RESET;
        cnt          <= '0;
        retry_cnt    <= '0;
        pll_rst      <= 1'b1;
        core_reset_n <= 1'b0;
        ready        <= 1'b0;
        fault        <= 1'b0;
      end else begin
        case (state)
          S_RESET: begin
            if (cnt >= RST_LAST) begin
              state   <= S_WAIT;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_WAIT: begin
            if (lock_s) begin
              // The cycle that sees lock counts as the first stable cycle.
              state <= S_STABLE;
              cnt   <= CW'(1);
            end else if (cnt >= TO_LAST) begin
              cnt <= '0;
              if (retry_cnt == RTY_LAST) begin
                state <= S_FAULT;
                fault <= 1'b1;
              end else begin
                state     <= S_RESET;
                retry_cnt <= retry_cnt + RW'(1);
                pll_rst   <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_STABLE: begin
            if (!lock_s) begin
              state <= S_WAIT;
              cnt   <= '0;
            end else if (cnt >= STB_LAST) begin
              state        <= S_RUN;
              cnt          <= '0;
              retry_cnt    <= '0;
              core_reset_n <= 1'b1;
              ready        <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_RUN: begin
            if (!lock_s) begin
              state        <= S_RESET;
              cnt          <= '0;
              pll_rst      <= 1'b1;
              core_reset_n <= 1'b0;
              ready        <= 1'b0;
              if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
            end
          end
          S_FAULT: begin
            pll_rst      <= 1'b0;
            core_reset_n <= 1'b0;
            ready        <= 1'b0;
          end
          default: begin
            state        <= S_RESET;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            ready        <= 1'b0;
            fault        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amiga_pll_sequencer.sv
// Directed bench for amiga_pll_sequencer with short timers.
// obs packs {state_o, pll_rst, core_reset_n, ready, fault}.
module tb_amiga_pll_sequencer;
  logic       clk_74a = 1'b0;
  logic       reset_n, pll_locked, reconfig_req;
  logic       pll_rst, core_reset_n, ready, fault;
  logic [7:0] loss_cnt;
  logic [2:0] state_o;
  logic [6:0] obs;
  int vecs = 0;
  int errs = 0;

  localparam logic [6:0] O_RESET  = 7'b000_1_0_0_0;
  localparam logic [6:0] O_WAIT   = 7'b001_0_0_0_0;
  localparam logic [6:0] O_STABLE = 7'b010_0_0_0_0;
  localparam logic [6:0] O_RUN    = 7'b011_0_1_1_0;
  localparam logic [6:0] O_FAULT  = 7'b100_0_0_0_1;

  amiga_pll_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(8), .MAX_RETRY(2)
  ) dut (
    .clk_74a(clk_74a), .reset_n(reset_n), .pll_locked(pll_locked),
    .reconfig_req(reconfig_req), .pll_rst(pll_rst), .core_reset_n(core_reset_n),
    .ready(ready), .fault(fault), .loss_cnt(loss_cnt), .state_o(state_o)
  );

  assign obs = {state_o, pll_rst, core_reset_n, ready, fault};

  always #5 clk_74a = ~clk_74a;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_74a);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; pll_locked = 1'b0; reconfig_req = 1'b0;
    tick(3);
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL reset_state: got %b want %b", obs, O_RESET); end
    vecs++;
    if (loss_cnt !== 8'd0) begin errs++; $display("FAIL reset_loss: got %0d want 0", loss_cnt); end
  endtask

  task automatic test_bringup;
    reset_n = 1'b1;
    tick(3);
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL bringup_rst3: got %b want %b", obs, O_RESET); end
    tick(1);
    vecs++;
    if (obs !== O_WAIT) begin errs++; $display("FAIL bringup_rst4: got %b want %b", obs, O_WAIT); end
    tick(20);
    pll_locked = 1'b1;
    tick(9);
    vecs++;
    if (obs !== O_STABLE) begin errs++; $display("FAIL bringup_pre_run: got %b want %b", obs, O_STABLE); end
    tick(1);
    vecs++;
    if (obs !== O_RUN) begin errs++; $display("FAIL bringup_run: got %b want %b", obs, O_RUN); end
  endtask

  task automatic test_glitch;
    // Restart from RUN with the PLL unlocked; reconfig must not count a loss.
    reconfig_req = 1'b1; pll_locked = 1'b0;
    tick(1);
    reconfig_req = 1'b0;
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL glitch_restart: got %b want %b", obs, O_RESET); end
    tick(3);
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL glitch_rst3: got %b want %b", obs, O_RESET); end
    tick(1);
    vecs++;
    if (obs !== O_WAIT) begin errs++; $display("FAIL glitch_wait: got %b want %b", obs, O_WAIT); end
    pll_locked = 1'b1;
    tick(7);
    vecs++;
    if (obs !== O_STABLE) begin errs++; $display("FAIL glitch_stable5: got %b want %b", obs, O_STABLE); end
    pll_locked = 1'b0;
    tick(3);
    vecs++;
    if (obs !== O_WAIT) begin errs++; $display("FAIL glitch_back_wait: got %b want %b", obs, O_WAIT); end
    pll_locked = 1'b1;
    tick(9);
    vecs++;
    if (obs !== O_STABLE) begin errs++; $display("FAIL glitch_full_count: got %b want %b", obs, O_STABLE); end
    tick(1);
    vecs++;
    if (obs !== O_RUN) begin errs++; $display("FAIL glitch_run: got %b want %b", obs, O_RUN); end
    vecs++;
    if (loss_cnt !== 8'd0) begin errs++; $display("FAIL glitch_loss: got %0d want 0", loss_cnt); end
  endtask

  task automatic test_run_loss;
    pll_locked = 1'b0;
    tick(2);
    vecs++;
    if (obs !== O_RUN) begin errs++; $display("FAIL loss_still_run: got %b want %b", obs, O_RUN); end
    tick(1);
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL loss_drop: got %b want %b", obs, O_RESET); end
    vecs++;
    if (loss_cnt !== 8'd1) begin errs++; $display("FAIL loss_cnt: got %0d want 1", loss_cnt); end
    tick(3);
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL loss_rst3: got %b want %b", obs, O_RESET); end
    tick(1);
    vecs++;
    if (obs !== O_WAIT) begin errs++; $display("FAIL loss_rst4: got %b want %b", obs, O_WAIT); end
    pll_locked = 1'b1;
    tick(10);
    vecs++;
    if (obs !== O_RUN) begin errs++; $display("FAIL loss_relock: got %b want %b", obs, O_RUN); end
  endtask

  task automatic test_reconfig_priority;
    pll_locked = 1'b0;
    tick(2);
    reconfig_req = 1'b1;
    tick(1);
    reconfig_req = 1'b0;
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL prio_state: got %b want %b", obs, O_RESET); end
    vecs++;
    if (loss_cnt !== 8'd1) begin errs++; $display("FAIL prio_loss: got %0d want 1", loss_cnt); end
  endtask

  task automatic test_retry_fault;
    tick(3);
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL retry_rst3: got %b want %b", obs, O_RESET); end
    tick(1);
    vecs++;
    if (obs !== O_WAIT) begin errs++; $display("FAIL retry_wait1: got %b want %b", obs, O_WAIT); end
    tick(99);
    vecs++;
    if (obs !== O_WAIT) begin errs++; $display("FAIL retry_tmo_early: got %b want %b", obs, O_WAIT); end
    tick(1);
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL retry_tmo1: got %b want %b", obs, O_RESET); end
    tick(3);
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL retry_rst3b: got %b want %b", obs, O_RESET); end
    tick(1);
    vecs++;
    if (obs !== O_WAIT) begin errs++; $display("FAIL retry_wait2: got %b want %b", obs, O_WAIT); end
    tick(100);
    vecs++;
    if (obs !== O_FAULT) begin errs++; $display("FAIL retry_fault: got %b want %b", obs, O_FAULT); end
    tick(5);
    vecs++;
    if (obs !== O_FAULT) begin errs++; $display("FAIL retry_fault_hold: got %b want %b", obs, O_FAULT); end
  endtask

  task automatic test_fault_reconfig;
    reconfig_req = 1'b1;
    tick(1);
    reconfig_req = 1'b0;
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL freconf_leave: got %b want %b", obs, O_RESET); end
    tick(3);
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL freconf_rst3: got %b want %b", obs, O_RESET); end
    tick(1);
    vecs++;
    if (obs !== O_WAIT) begin errs++; $display("FAIL freconf_rst4: got %b want %b", obs, O_WAIT); end
    pll_locked = 1'b1;
    tick(10);
    vecs++;
    if (obs !== O_RUN) begin errs++; $display("FAIL freconf_run: got %b want %b", obs, O_RUN); end
  endtask

  task automatic test_async_reset;
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if (obs !== O_RESET) begin errs++; $display("FAIL async_state: got %b want %b", obs, O_RESET); end
    vecs++;
    if (loss_cnt !== 8'd0) begin errs++; $display("FAIL async_loss: got %0d want 0", loss_cnt); end
    tick(2);
    reset_n = 1'b1;
    tick(4);
    vecs++;
    if (obs !== O_WAIT) begin errs++; $display("FAIL async_restart: got %b want %b", obs, O_WAIT); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_run_loss();
    test_reconfig_priority();
    test_retry_fault();
    test_fault_reconfig();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
